// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter slice:
//   - 4-bit ALU select encodings (OP_ADD .. OP_LT) and OP_LAST, the highest
//     legal code; codes above OP_LAST are illegal.
//   - arb_state_e, the arbiter FSM state type.
//   - is_illegal_op(), which classifies a select code.
// ----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_INC = 4'd8,
        OP_DEC = 4'd9,
        OP_EQ  = 4'd10,
        OP_LT  = 4'd11
    } alu_op_e;

    localparam logic [3:0] OP_LAST = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op > OP_LAST);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   req[1:0]   : pending requests
//   en         : arbitration enabled this cycle (grants are only issued and
//                the pointer only moves while en is high)
//   gnt[1:0]   : one-hot grant, combinational from req/en/pointer
// The priority pointer starts at requester 0. After every grant it moves to
// the requester that was not granted, so two persistent requesters alternate
// and a sole requester always wins.
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr;

    // The requester named by the pointer wins a tie; otherwise the other
    // requester takes the grant if it is asking.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[ptr]) begin
                gnt[ptr] = 1'b1;
            end else if (req[ptr ^ 1'b1]) begin
                gnt[ptr ^ 1'b1] = 1'b1;
            end
        end
    end

    // A grant to requester 0 hands priority to requester 1 and vice versa.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (|gnt) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two requesters. An operation is
// accepted in IDLE, driven onto the ALU in EXEC, and presented as a response
// in RESP until the consumer takes it.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   reqN_valid / reqN_ready     : request handshake per requester (N = 0, 1)
//   reqN_op, reqN_a, reqN_b     : select code and operands per requester
//   alu_a, alu_b, alu_sel       : operands/select driven to the shared ALU
//   alu_c                       : combinational result returned by the ALU
//   rsp_valid / rsp_ready       : response handshake
//   rsp_data, rsp_id, rsp_err   : result, owning requester, illegal-op flag
//   gnt0_cnt, gnt1_cnt          : saturating accept counts (ALU_ARB_CNT_EN)
// Configuration: define ALU_ARB_CNT_EN to add the per-requester grant counters
// and their output ports.
// ----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [3:0]   req0_op,
    input  logic [3:0]   req1_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_sel,
    input  logic [W-1:0] alu_c,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_id,
    output logic         rsp_err
`ifdef ALU_ARB_CNT_EN
    ,
    output logic [7:0]   gnt0_cnt,
    output logic [7:0]   gnt1_cnt
`endif
);

    arb_state_e     state_q;
    arb_state_e     state_d;
    logic [1:0]     gnt;
    logic           arb_en;
    logic [3:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           id_q;
    logic           op_bad;

    // Grants are only possible in IDLE; gating with rst_n keeps the ready
    // outputs low while reset is held even if a requester is already valid.
    assign arb_en = (state_q == ST_IDLE) && rst_n;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({req1_valid, req0_valid}),
        .en    (arb_en),
        .gnt   (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // ALU inputs come straight from the operand registers, which only change
    // on an accepting edge, so request-side activity never reaches the ALU.
    // Illegal codes are replaced by 0 so the ALU never sees them.
    assign op_bad  = is_illegal_op(op_q);
    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_sel = op_bad ? 4'b0000 : op_q;

    assign rsp_valid = (state_q == ST_RESP);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one cycle each in IDLE (on accept) and EXEC, then
    // RESP holds until the consumer takes the response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|gnt)     state_d = ST_EXEC;
            ST_EXEC:               state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // Operand capture on accept; result capture at the end of EXEC. The
    // response fields are only rewritten in EXEC, so they stay stable for
    // the whole of RESP regardless of how long the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 4'b0000;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= 1'b0;
            rsp_data <= '0;
            rsp_id   <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            if (|gnt) begin
                op_q <= gnt[1] ? req1_op : req0_op;
                a_q  <= gnt[1] ? req1_a  : req0_a;
                b_q  <= gnt[1] ? req1_b  : req0_b;
                id_q <= gnt[1];
            end
            if (state_q == ST_EXEC) begin
                rsp_data <= op_bad ? '0 : alu_c;
                rsp_id   <= id_q;
                rsp_err  <= op_bad;
            end
        end
    end

`ifdef ALU_ARB_CNT_EN
    // Per-requester accept counters that stick at 8'hFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0_cnt <= 8'd0;
            gnt1_cnt <= 8'd0;
        end else begin
            if (gnt[0] && (gnt0_cnt != 8'hFF)) begin
                gnt0_cnt <= gnt0_cnt + 8'd1;
            end
            if (gnt[1] && (gnt1_cnt != 8'hFF)) begin
                gnt1_cnt <= gnt1_cnt + 8'd1;
            end
        end
    end
`endif

endmodule
